// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues word reads over req/ack,
// and buffers {pc, instr} pairs for decode as a first-word-fall-through FIFO.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_mem_q    [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic               has_space;

  assign out_valid = (count_q != '0);
  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;
  assign count     = count_q;
  assign out_pc    = pc_mem_q[head_q];
  assign out_instr = instr_mem_q[head_q];

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    push       = (state_q == WAIT) && mem_ack && !redirect;
    pop        = out_valid && out_ready && !redirect;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d     = head_q;
    tail_d     = tail_q;
    fetch_pc_d = fetch_pc_q;

    if (redirect) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (push) begin
        tail_d     = tail_q + 1'b1;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
    end

    has_space = (count_d < CNT_W'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!redirect && has_space) state_d = WAIT;
      end
      WAIT: begin
        if (redirect)     state_d = mem_ack ? IDLE : DROP;
        else if (mem_ack) state_d = has_space ? WAIT : IDLE;
      end
      DROP: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An abandoned request must keep its address until the memory acks it.
    mem_addr_d = (state_d == DROP) ? mem_addr_q : fetch_pc_d;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // NOTE: entries are reset because out_pc/out_instr expose the head slot
  // even when empty and must read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]    <= fetch_pc_q;
      instr_mem_q[tail_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed phases push expected {pc} entries,
// negedge monitors pop and compare whenever decode accepts an entry.
module tb_ifetch_queue;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0) with a variable-latency memory model
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_instr;
  logic [2:0]  count;
  int          lat = 0;
  int          wait_cnt;

  // Second instance exercising the address wrap from a high RESET_PC
  logic        rst2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic        mem_req2, mem_ack2;
  logic [31:0] mem_addr2, mem_rdata2;
  logic        out_valid2, out_ready2 = 1'b0;
  logic [31:0] out_pc2, out_instr2;
  logic [2:0]  count2;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
    .out_valid(out_valid2), .out_pc(out_pc2), .out_instr(out_instr2),
    .out_ready(out_ready2), .count(count2)
  );

  // Memory: acks once the request has been held for lat cycles
  always_comb begin
    mem_ack    = mem_req && (wait_cnt >= lat);
    mem_rdata  = mem_addr ^ XOR_KEY;
    mem_ack2   = mem_req2;
    mem_rdata2 = mem_addr2 ^ XOR_KEY;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst)                     wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst && out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_out: got pc %h, expected no entry (t=%0t)", out_pc, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", out_instr, e ^ XOR_KEY);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e2;
    if (rst2 && out_valid2 && out_ready2) begin
      if (exp2_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_out2: got pc %h, expected no entry (t=%0t)", out_pc2, $time);
      end else begin
        e2 = exp2_q.pop_front();
        check("wrap_out_pc", out_pc2, e2);
        check("wrap_out_instr", out_instr2, e2 ^ XOR_KEY);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    redirect  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);

    // Zero-wait streaming, one instruction per cycle
    lat = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    rst = 1'b1;
    step();
    check("s1_mem_req_rise", mem_req, 1);
    check("s1_mem_addr0", mem_addr, 32'h0);
    check("s1_no_valid_yet", out_valid, 0);
    step();
    check("s1_valid_cycle2", out_valid, 1);
    check("s1_count1", count, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("s1_count_le1", 32'(count <= 3'd1), 1);
    end
    wait_drain(20);
    apply_reset();

    // Back-pressure: exactly DEPTH words fetched, then resume at 0x10
    rst = 1'b1;
    repeat (8) step();
    check("bp_count_full", count, 4);
    check("bp_mem_req_low", mem_req, 0);
    check("bp_mem_addr", mem_addr, 32'h10);
    check("bp_head_pc", out_pc, 32'h0);
    foreach (exp_q[i]) ;
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    out_ready = 1'b1;
    wait_drain(40);
    apply_reset();

    // Three-cycle memory latency: stable request, one push per ack
    lat = 3;
    out_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("lat_req_held", mem_req, 1);
      check("lat_addr_stable", mem_addr, 32'h0);
      check("lat_no_push", count, 0);
    end
    step();
    check("lat_one_push", count, 1);
    check("lat_next_addr", mem_addr, 32'h4);
    wait_drain(40);
    apply_reset();

    // Redirect while the fetch of 0x8 is outstanding
    lat = 3;
    out_ready = 1'b1;
    exp_q.push_back(32'h0);   exp_q.push_back(32'h4);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    rst = 1'b1;
    begin
      int n = 0;
      while (mem_addr != 32'h8 && n < 40) begin
        step();
        n++;
      end
      check("rd_reach_addr8", mem_addr, 32'h8);
    end
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect    = 1'b0;
    check("rd_flush_valid", out_valid, 0);
    check("rd_flush_count", count, 0);
    check("rd_drop_req", mem_req, 1);
    check("rd_drop_addr", mem_addr, 32'h8);
    begin
      int n = 0;
      while (mem_req && n < 20) begin
        step();
        n++;
      end
      check("rd_drop_done", mem_req, 0);
    end
    check("rd_new_addr", mem_addr, 32'h100);
    check("rd_no_stale", count, 0);
    wait_drain(40);
    apply_reset();

    // Redirect coinciding with ack and pop at count=2
    lat = 0;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("co_count2", count, 2);
    check("co_req", mem_req, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    out_ready   = 1'b1;
    step();
    redirect = 1'b0;
    check("co_count0", count, 0);
    check("co_idle", mem_req, 0);
    check("co_valid0", out_valid, 0);
    check("co_addr", mem_addr, 32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    wait_drain(20);
    apply_reset();

    // PC wrap from RESET_PC = FFFF_FFF8, then asynchronous reset mid-stream
    exp2_q.push_back(32'hFFFF_FFF8);
    exp2_q.push_back(32'hFFFF_FFFC);
    exp2_q.push_back(32'h0000_0000);
    exp2_q.push_back(32'h0000_0004);
    out_ready2 = 1'b1;
    rst2 = 1'b1;
    begin
      int n = 0;
      while (exp2_q.size() != 0 && n < 20) begin
        step();
        n++;
      end
      check("wrap_drain_remaining", exp2_q.size(), 0);
    end
    out_ready2 = 1'b0;
    step();
    check("wrap_busy_before_rst", out_valid2, 1);
    #3;
    rst2 = 1'b0;
    #1;
    check("arst_mem_req", mem_req2, 0);
    check("arst_mem_addr", mem_addr2, 32'hFFFF_FFF8);
    check("arst_count", count2, 0);
    check("arst_out_valid", out_valid2, 0);
    check("arst_out_pc", out_pc2, 32'h0);
    check("arst_out_instr", out_instr2, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue between the PC/instruction-memory side and the IF/ID pipeline register. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. It buffers up to DEPTH fetched {pc, instr} pairs and presents them first-word-fall-through to the decode stage with valid/ready. A branch/jump redirect resolved in ID flushes the queue and discards any in-flight fetch.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000: fetch PC after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- redirect  in  1  flush queue, restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- mem_req  out  1  fetch request, held until mem_ack
- mem_addr  out  32  word address of current request, stable while mem_req=1
- mem_ack  in  1  read complete; mem_rdata valid this cycle; ignored when mem_req=0
- mem_rdata  in  32  instruction word
- out_valid  out  1  head entry valid (queue non-empty)
- out_pc  out  32  PC of head entry
- out_instr  out  32  instruction of head entry
- out_ready  in  1  decode accepts head entry this cycle
- count  out  log2(DEPTH)+1  occupied entries

## Operation
- FSM states: IDLE (no request outstanding), WAIT (request outstanding, data kept), DROP (request outstanding, data to be discarded). mem_req = (state != IDLE), registered.
- fetch_pc register drives mem_addr. It increments by 4 only on an accepted ack in WAIT and wraps 32'hFFFF_FFFC -> 0.
- Space rule: next_count = count + push - pop. A new request is started/continued only if next_count < DEPTH. With one request outstanding at most, push never overflows.
- IDLE: if !redirect and space, go to WAIT.
- WAIT, mem_ack, !redirect: push {fetch_pc, mem_rdata} and fetch_pc += 4. Go to WAIT (back-to-back, new address) if space, else IDLE.
- WAIT, !mem_ack: hold.
- Redirect in any state: queue emptied (count=0) and fetch_pc = {redirect_pc[31:2], 2'b00}. A pop in the same cycle is ignored.
  - From IDLE: go to IDLE.
  - From WAIT or DROP without ack: go to DROP; the request stays asserted with its old address until ack.
  - From WAIT or DROP with ack in the same cycle: data discarded, go to IDLE.
- DROP, mem_ack, !redirect: discard data, go to IDLE. fetch_pc unchanged.
- Pop: out_valid & out_ready & !redirect; advances head.
- Simultaneous push and pop: count unchanged; works at count=0 only if out_valid was already 1, i.e. no bypass.
- Entry storage is a circular buffer with head/tail pointers of width log2(DEPTH) that wrap naturally.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_addr=RESET_PC, count=0, out_valid=0, out_pc=0, out_instr=0; all entries cleared.
- mem_req rises the first cycle after leaving reset, if no redirect is present.
- mem_ack may arrive in the same cycle mem_req first rises (zero-wait memory).
- Push on the ack edge; out_valid=1 on the following cycle. Ack-to-decode latency is 1 cycle; there is no combinational path from mem_rdata to out_*.
- Zero-wait memory with out_ready=1 sustains 1 instruction/cycle.
- out_valid, out_pc, out_instr depend only on registers.
- redirect asserted at edge N: out_valid=0 from N+1. The first instruction from redirect_pc reaches the output no earlier than 2 cycles after the in-flight request's ack (DROP) or N+2 (IDLE with zero-wait memory).
- Async reset mid-request drops mem_req immediately. The memory must tolerate an abandoned request.

## Test plan
- Reset release, memory acks every cycle with rdata = addr ^ 32'hA5A5_0000, out_ready=1: out_pc sequence 0,4,8,C… one per cycle from cycle 2; out_instr matches; count ≤1.
- out_ready=0 with zero-wait memory: exactly DEPTH (4) words fetched, then mem_req=0, count=4. Raise out_ready: entries 0,4,8,C drain in order and fetch resumes at 10.
- Memory ack delayed 3 cycles: mem_addr stays stable, mem_req stays high for the full wait, and exactly one push occurs per ack.
- redirect to 32'h0000_0103 while a request to 8 is pending: queue empties the next cycle and the ack for 8 is discarded. The next request address is 32'h0000_0100, and out_pc 100 appears with no stale entry.
- redirect asserted in the same cycle as mem_ack and out_ready with count=2: no push, no pop, count=0, state IDLE, next mem_addr = redirect target.
- RESET_PC=32'hFFFF_FFF8, zero-wait: out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap). Assert rst mid-stream: all outputs return to reset values asynchronously.
